// File: rtl/mac_rr_scheduler.sv
// Round-robin front end sharing one unstallable pipelined MAC among NREQ requesters.
// Results return in issue order through a credit-protected response FIFO.
module mac_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int LOGA  = 60,
    parameter int LOGB  = 60,
    parameter int LOGE  = 32,
    parameter int LOGC  = 121,
    parameter int LAT   = 3,
    parameter int DEPTH = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*LOGA-1:0] req_a,
    input  logic [NREQ*LOGB-1:0] req_b,
    input  logic [NREQ*LOGE-1:0] req_e,
    output logic [LOGA-1:0]      mac_a,
    output logic [LOGB-1:0]      mac_b,
    output logic [LOGE-1:0]      mac_e,
    input  logic [LOGC-1:0]      mac_c,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [LOGC-1:0]      rsp_c,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]   credit_q, credit_d;
    logic [IDW-1:0]  ptr_q;
    logic [NREQ-1:0] above, masked, gnt;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_idx;

    logic [LAT-1:0]          vld_q;
    logic [LAT-1:0][IDW-1:0] id_q;

    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q;
    logic [LOGC-1:0] mem_c  [DEPTH];
    logic [IDW-1:0]  mem_id [DEPTH];
    logic            push, pop;

    // Requesters above ptr win first; otherwise wrap to the lowest valid one.
    always_comb begin
        above   = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) above[i] = (i > int'(ptr_q));
        masked = req_valid & above;
        if (rst_n && credit_q != '0) begin
            for (int i = NREQ - 1; i >= 0; i--)
                if (req_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IDW'(i);
                end
            for (int i = NREQ - 1; i >= 0; i--)
                if (masked[i]) gnt_idx = IDW'(i);
        end
        gnt = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    end

    assign req_ready = gnt;
    assign mac_a     = gnt_vld ? req_a[gnt_idx*LOGA +: LOGA] : '0;
    assign mac_b     = gnt_vld ? req_b[gnt_idx*LOGB +: LOGB] : '0;
    assign mac_e     = gnt_vld ? req_e[gnt_idx*LOGE +: LOGE] : '0;

    assign push      = vld_q[LAT-1];
    assign rsp_valid = cnt_q != '0;
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_c     = rsp_valid ? mem_c[rptr_q]  : '0;
    assign rsp_id    = rsp_valid ? mem_id[rptr_q] : '0;
    assign busy      = credit_q != CW'(DEPTH);

    always_comb begin
        credit_d = credit_q;
        case ({gnt_vld, pop})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= CW'(DEPTH);
            ptr_q    <= IDW'(NREQ - 1);
            vld_q    <= '0;
            id_q     <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            credit_q <= credit_d;
            if (gnt_vld) ptr_q <= gnt_idx;
            vld_q[0] <= gnt_vld;
            id_q[0]  <= gnt_idx;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage needs no reset: the head is masked by rsp_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_c[wptr_q]  <= mac_c;
            mem_id[wptr_q] <= id_q[LAT-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (cnt_q < CW'(DEPTH)));

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Randomized + directed bench for mac_rr_scheduler with a behavioural MAC and
// a transaction-level scoreboard of arbitration, credit and response order.
module tb_mac_rr_scheduler;
    localparam int NREQ = 4, LOGA = 60, LOGB = 60, LOGE = 32, LOGC = 121;
    localparam int LAT = 3, DEPTH = 4, IDW = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*LOGA-1:0] req_a;
    logic [NREQ*LOGB-1:0] req_b;
    logic [NREQ*LOGE-1:0] req_e;
    logic [LOGA-1:0]      mac_a;
    logic [LOGB-1:0]      mac_b;
    logic [LOGE-1:0]      mac_e;
    logic [LOGC-1:0]      mac_c;
    logic                 rsp_valid, rsp_ready, busy;
    logic [LOGC-1:0]      rsp_c;
    logic [IDW-1:0]       rsp_id;

    logic [LOGA-1:0] a_r [NREQ];
    logic [LOGB-1:0] b_r [NREQ];
    logic [LOGE-1:0] e_r [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*LOGA +: LOGA] = a_r[i];
            req_b[i*LOGB +: LOGB] = b_r[i];
            req_e[i*LOGE +: LOGE] = e_r[i];
        end
    end

    mac_rr_scheduler #(.NREQ(NREQ), .LOGA(LOGA), .LOGB(LOGB), .LOGE(LOGE),
        .LOGC(LOGC), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_e(req_e),
        .mac_a(mac_a), .mac_b(mac_b), .mac_e(mac_e), .mac_c(mac_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
        .rsp_id(rsp_id), .busy(busy));

    // Free-running MAC: LAT register stages, no reset, no stall.
    logic [LOGC-1:0] mpipe [LAT];
    initial for (int i = 0; i < LAT; i++) mpipe[i] = '0;
    always @(posedge clk) begin
        mpipe[0] <= LOGC'(mac_a) * LOGC'(mac_b) + LOGC'(mac_e);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mac_c = mpipe[LAT-1];

    typedef struct { logic [LOGC-1:0] c; int id; int t; } exp_t;
    exp_t exp_q[$];
    int cyc = 0, issued = 0, popped = 0, ptr_m = NREQ - 1;
    int errors = 0, checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue side: predict the grant from credit and RR order, log expected results.
    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        int credit_m, idx, id;
        if (rst_n) begin
            credit_m = DEPTH - (issued - popped);
            eg = '0;
            if (credit_m > 0)
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (ptr_m + k) % NREQ;
                    if (req_valid[idx] && eg == '0) eg[idx] = 1'b1;
                end
            chk("grant", req_ready, eg);
            chk("busy", busy, issued != popped);
            if (req_ready != '0) begin
                id = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
                chk("mac_a", mac_a, a_r[id]);
                chk("mac_b", mac_b, b_r[id]);
                chk("mac_e", mac_e, e_r[id]);
                exp_q.push_back('{c: LOGC'(a_r[id]) * LOGC'(b_r[id]) + LOGC'(e_r[id]),
                                  id: id, t: cyc});
                issued++;
                ptr_m = id;
            end
        end
    end

    // Response side: head becomes visible LAT+1 cycles after issue, in order.
    always @(negedge clk) begin
        exp_t e;
        bit ev;
        #1;
        if (rst_n) begin
            ev = exp_q.size() > 0 && exp_q[0].t <= cyc - (LAT + 1);
            chk("rsp_valid", rsp_valid, ev);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_c", rsp_c, e.c);
                    chk("rsp_id", rsp_id, e.id);
                end
                popped++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_c"}, rsp_c, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_mac_a"}, mac_a, 0);
    endtask

    initial begin
        int i0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_r[i] = '0; b_r[i] = '0; e_r[i] = '0;
        end
        req_valid = 4'b1111;
        repeat (3) tick();
        chk_zero_outputs("reset");
        req_valid = '0;
        rst_n = 1'b1;
        tick();

        // Single op from requester 2: 3*5+7 = 22.
        a_r[2] = 3; b_r[2] = 5; e_r[2] = 7;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (8) tick();

        // All requesters valid, A=i+1, B=10.
        for (int i = 0; i < NREQ; i++) begin
            a_r[i] = LOGA'(i + 1); b_r[i] = 10; e_r[i] = 0;
        end
        req_valid = 4'b1111;
        repeat (16) tick();
        req_valid = '0;
        repeat (8) tick();

        // Only 1 and 3 valid.
        req_valid = 4'b1010;
        repeat (12) tick();
        req_valid = '0;
        repeat (8) tick();

        // Backpressure: fill, then one pop frees exactly one grant next cycle.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        i0 = issued;
        repeat (10) tick();
        chk("full_handshakes", issued - i0, 4);
        chk("full_ready", req_ready, 0);
        rsp_ready = 1'b1;
        i0 = issued;
        tick();
        rsp_ready = 1'b0;
        chk("no_grant_in_pop_cycle", issued - i0, 0);
        tick();
        chk("one_grant_after_pop", issued - i0, 1);
        repeat (6) tick();
        chk("still_one_grant", issued - i0, 1);

        // Release backpressure with traffic still arriving.
        rsp_ready = 1'b1;
        repeat (14) tick();
        req_valid = '0;
        repeat (8) tick();

        // Reset with two queued and two in flight.
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_r[i] = LOGA'(100 + i); b_r[i] = LOGB'(7 + i); e_r[i] = LOGE'(i);
        end
        req_valid = 4'b1111;
        repeat (5) tick();
        rst_n = 1'b0;
        exp_q.delete();
        issued = 0; popped = 0; ptr_m = NREQ - 1;
        #1;
        chk_zero_outputs("midreset");
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        rsp_ready = 1'b1;
        a_r[0] = 11; b_r[0] = 13; e_r[0] = 17;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (10) tick();
        chk("post_reset_drained", exp_q.size(), 0);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_r[i] = LOGA'({$urandom, $urandom});
                b_r[i] = LOGB'({$urandom, $urandom});
                e_r[i] = LOGE'($urandom);
            end
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) tick();
        chk("final_drained", exp_q.size(), 0);
        chk("final_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
